spram_arbiter: RTL
==================

Name: spram_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port 16K x 32 SoC SPRAM (1-cycle registered read, per-byte write enables). It shares the RAM between the CPU native memory port and the AES coprocessor DMA port, both using the valid/ready/wstrb handshake. It sits between the SoC bus decode and the SPRAM instance. It issues exactly one RAM access per granted request and returns read data with a single-cycle ready pulse.

Parameters:
ADDR_W, 14, RAM word-address width; requesters use byte-address bits [ADDR_W+1:2]
MAX_LOCK, 8, maximum consecutive DMA grants under lock (optional feature only); range 1..255

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_valid  in  1  CPU request; held high until cpu_ready
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_wstrb  in  4  CPU byte strobes; 0 means read
cpu_ready  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  32  read data; valid only while cpu_ready is high
dma_valid, dma_addr, dma_wdata, dma_wstrb, dma_ready, dma_rdata  same as the cpu_* ports, for the AES DMA
dma_lock  in  1  DMA requests back-to-back ownership (optional feature)
ram_wen  out  4  SPRAM byte write enables
ram_addr  out  ADDR_W  SPRAM word address
ram_wdata  out  32  SPRAM write data
ram_rdata  in  32  SPRAM registered read data
busy  out  1  high in ISSUE and DONE
grant  out  1  owner of the current or last access: 0 = CPU, 1 = DMA

Behaviour:
- FSM states: IDLE -> ISSUE -> DONE -> IDLE. Each state lasts one cycle.
- IDLE:
  - If any valid is high, pick a winner and register its addr[ADDR_W+1:2], wdata and wstrb into a request holding register.
  - Set grant to the winner and move to ISSUE.
  - If no valid is high, stay in IDLE.
- Arbitration: round-robin on ties. If both valids are high, the requester not granted last wins. A single requester always wins.
- ISSUE:
  - ram_addr and ram_wdata come from the holding register.
  - ram_wen = held wstrb, asserted only in this cycle.
  - The RAM samples at the end of ISSUE.
- DONE:
  - The winner's ready is high for exactly this cycle.
  - The winner's rdata = ram_rdata. For a write, rdata is the old word; the CPU ignores it.
  - Next state is IDLE.
- Latency: request valid in cycle N (FSM in IDLE) -> ready in cycle N+2.
  - Next arbitration happens in N+3, so sustained throughput is one access per 3 cycles.
- Outside DONE: ready = 0 and rdata = 32'h0 on both ports. ram_wen = 0 outside ISSUE.
- ram_addr and ram_wdata hold their last value when not in ISSUE. The RAM ignores them because wen = 0.
- A requester dropping valid before ready is a protocol violation. The access still completes and the ready pulse is still issued.
- A request arriving while busy waits. It is arbitrated in the next IDLE cycle.
- Reset:
  - FSM -> IDLE.
  - All outputs 0: ram_wen, ram_addr, ram_wdata, cpu/dma ready, cpu/dma rdata, busy, grant.
  - The "last granted" pointer resets to DMA, so the CPU wins the first tie.
- Reset mid-operation:
  - ram_wen is combinationally gated by !reset, so no write commits in a cycle where reset is high.
  - An in-flight request is dropped and no ready is issued. The requester re-requests from IDLE after reset.
- Address bits above ADDR_W+1 and bits [1:0] are ignored; addresses alias. Range decode is done upstream.

Optional Feature:
SPRAM_ARB_LOCK_EN
- Defined:
  - While DMA holds the grant and dma_lock is high, each IDLE arbitration grants DMA if dma_valid is high, regardless of round-robin.
  - An 8-bit lock counter increments per locked DMA grant.
  - When the counter reaches MAX_LOCK and cpu_valid is high, the CPU gets the next grant.
  - The counter clears on any CPU grant, when dma_lock is low, and on reset.
- Undefined:
  - The dma_lock port still exists but is ignored. Pure round-robin applies and no counter is synthesized.

Test Plan:
- CPU read: preload RAM[5] = 32'hDEADBEEF; cpu_valid, addr 32'h14, wstrb 0 -> cpu_ready one cycle 2 cycles later; cpu_rdata = DEADBEEF; ram_wen never nonzero.
- DMA partial write: dma_addr 32'h20, wdata 32'h11223344, wstrb 4'b0101 over RAM[8] = 32'hAABBCCDD -> ram_wen = 0101 in ISSUE only; a later read returns 32'hAA22CC44.
- Contention: both valid from the cycle after reset, each re-requesting immediately -> grants alternate CPU, DMA, CPU, DMA; readies 3 cycles apart; never both high in one cycle.
- Reset mid-write: assert reset in the ISSUE cycle of a CPU write of 32'hFFFFFFFF to RAM[3] = 0 -> RAM[3] stays 0; all outputs 0 the next cycle; FSM in IDLE.
- Idle/aliasing: cpu_addr 32'h0001_0004 -> ram_addr = 1; with no valid for 10 cycles, busy = 0 and ready = 0 throughout.
- Lock (SPRAM_ARB_LOCK_EN, MAX_LOCK = 2): dma_lock high, both valid continuously after one DMA grant -> sequence DMA, DMA, DMA (counter hits 2), then CPU; without the macro -> strict alternation.

Source files
------------

// File: rtl/spram_arbiter.sv
// spram_arbiter: round-robin CPU/DMA arbiter and IDLE->ISSUE->DONE sequencer for the 1-cycle SPRAM.
// Optional DMA lock (back-to-back DMA grants, capped at MAX_LOCK) is built only when SPRAM_ARB_LOCK_EN is defined.

module spram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,

  input  logic              dma_valid,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_wstrb,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  input  logic              dma_lock,

  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,

  output logic              busy,
  output logic              grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state;
  logic       rr_last;     // last granted requester, 1 = DMA
  logic [3:0] hold_wstrb;
  logic       any_valid;
  logic       pick_dma;
  logic       done_live;

`ifdef SPRAM_ARB_LOCK_EN
  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  logic [7:0] lock_cnt;
  logic       lock_hold;
  logic       unused_bits;

  assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                         dma_addr[31:ADDR_W+2], dma_addr[1:0]};
`else
  logic unused_bits;

  assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                         dma_addr[31:ADDR_W+2], dma_addr[1:0], dma_lock};
`endif

  assign any_valid = cpu_valid | dma_valid;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick_dma = dma_valid;
    if (cpu_valid && dma_valid) begin
      pick_dma = ~rr_last;
    end
`ifdef SPRAM_ARB_LOCK_EN
    lock_hold = grant & dma_lock & dma_valid;
    if (lock_hold) begin
      pick_dma = !((lock_cnt >= LOCK_LIMIT) && cpu_valid);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      rr_last    <= 1'b1;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      hold_wstrb <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant      <= pick_dma;
            rr_last    <= pick_dma;
            ram_addr   <= pick_dma ? dma_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
            ram_wdata  <= pick_dma ? dma_wdata : cpu_wdata;
            hold_wstrb <= pick_dma ? dma_wstrb : cpu_wstrb;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPRAM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset || !dma_lock) begin
      lock_cnt <= 8'd0;
    end else if (state == S_IDLE && any_valid) begin
      if (!pick_dma) begin
        lock_cnt <= 8'd0;
      end else if (lock_hold && lock_cnt != 8'hFF) begin
        lock_cnt <= lock_cnt + 8'd1;
      end
    end
  end
`endif

  // Reset gates the write strobe combinationally so a write caught mid-ISSUE never commits.
  assign ram_wen   = (state == S_ISSUE && !reset) ? hold_wstrb : 4'h0;

  assign done_live = (state == S_DONE) && !reset;
  assign cpu_ready = done_live && !grant;
  assign dma_ready = done_live && grant;
  assign cpu_rdata = cpu_ready ? ram_rdata : 32'h0;
  assign dma_rdata = dma_ready ? ram_rdata : 32'h0;
  assign busy      = (state == S_ISSUE || state == S_DONE) && !reset;

endmodule
